// File: rtl/battle_phase_ctrl_if.sv
// rtl/battle_phase_ctrl_if.sv - player/board/display signal bundle for battle_phase_ctrl
interface battle_phase_ctrl_if;
  logic       tick_1hz;
  logic       confirm;
  logic [2:0] ship_amount;
  logic       place_valid;
  logic       shot_valid;
  logic       result_valid;
  logic       result_sunk;
  logic [3:0] state;
  logic       ships_decided;
  logic       place_strobe;
  logic [2:0] ships_placed;
  logic       fire_strobe;
  logic       auto_fire;
  logic       pc_fire_strobe;
  logic [3:0] turn_timer;
  logic [2:0] player_score;
  logic [2:0] pc_score;

  modport slave (
    input  tick_1hz, confirm, ship_amount, place_valid, shot_valid, result_valid, result_sunk,
    output state, ships_decided, place_strobe, ships_placed, fire_strobe, auto_fire,
           pc_fire_strobe, turn_timer, player_score, pc_score
  );

  modport master (
    output tick_1hz, confirm, ship_amount, place_valid, shot_valid, result_valid, result_sunk,
    input  state, ships_decided, place_strobe, ships_placed, fire_strobe, auto_fire,
           pc_fire_strobe, turn_timer, player_score, pc_score
  );
endinterface

// File: rtl/battle_phase_ctrl.sv
// rtl/battle_phase_ctrl.sv - battleship game phase sequencer (decide, place, alternate turns, win/lose)
module battle_phase_ctrl #(
  parameter int TURN_SECS = 15,
  parameter int MAX_SHIPS = 5
) (
  input logic               clk,
  input logic               rst,
  battle_phase_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DECIDE  = 4'd1,
    PLACE   = 4'd2,
    P_TURN  = 4'd3,
    P_WAIT  = 4'd4,
    PC_TURN = 4'd5,
    PC_WAIT = 4'd6,
    WIN     = 4'd7,
    LOSE    = 4'd8
  } phase_e;

  localparam logic [3:0] TURN_RELOAD = 4'(TURN_SECS);
  localparam logic [2:0] MAX_AMOUNT  = 3'(MAX_SHIPS);

  phase_e     state_q, state_d;
  logic       confirm_q;
  logic [2:0] amount_q, amount_d;
  logic [2:0] ships_placed_q, ships_placed_d;
  logic [2:0] player_score_q, player_score_d;
  logic [2:0] pc_score_q, pc_score_d;
  logic [3:0] turn_timer_q, turn_timer_d;
  logic       ships_decided_q, ships_decided_d;
  logic       place_strobe_q, place_strobe_d;
  logic       fire_strobe_q, fire_strobe_d;
  logic       auto_fire_q, auto_fire_d;
  logic       pc_fire_strobe_q, pc_fire_strobe_d;

  logic       press;
  logic [2:0] player_score_inc;
  logic [2:0] pc_score_inc;

  assign press            = bus.confirm & ~confirm_q;
  assign player_score_inc = player_score_q + {2'b00, bus.result_sunk};
  assign pc_score_inc     = pc_score_q + {2'b00, bus.result_sunk};

  always_comb begin
    state_d          = state_q;
    amount_d         = amount_q;
    ships_placed_d   = ships_placed_q;
    player_score_d   = player_score_q;
    pc_score_d       = pc_score_q;
    turn_timer_d     = turn_timer_q;
    ships_decided_d  = 1'b0;
    place_strobe_d   = 1'b0;
    fire_strobe_d    = 1'b0;
    auto_fire_d      = 1'b0;
    pc_fire_strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (press) begin
          state_d        = DECIDE;
          amount_d       = 3'd0;
          ships_placed_d = 3'd0;
          player_score_d = 3'd0;
          pc_score_d     = 3'd0;
        end
      end
      DECIDE: begin
        if (press && bus.ship_amount != 3'd0 && bus.ship_amount <= MAX_AMOUNT) begin
          amount_d        = bus.ship_amount;
          ships_decided_d = 1'b1;
          state_d         = PLACE;
        end
      end
      PLACE: begin
        // The full-fleet check takes priority so the count can never overshoot.
        if (ships_placed_q >= amount_q) begin
          state_d      = P_TURN;
          turn_timer_d = TURN_RELOAD;
        end else if (press && bus.place_valid) begin
          ships_placed_d = ships_placed_q + 3'd1;
          place_strobe_d = 1'b1;
        end
      end
      P_TURN: begin
        if (bus.tick_1hz && turn_timer_q != 4'd0) begin
          turn_timer_d = turn_timer_q - 4'd1;
        end
        if (press && bus.shot_valid) begin
          fire_strobe_d = 1'b1;
          state_d       = P_WAIT;
        end else if (bus.tick_1hz && turn_timer_q == 4'd1) begin
          fire_strobe_d = 1'b1;
          auto_fire_d   = 1'b1;
          state_d       = P_WAIT;
        end
      end
      P_WAIT: begin
        if (bus.result_valid) begin
          player_score_d = player_score_inc;
          if (player_score_inc == amount_q) begin
            state_d = WIN;
          end else begin
            state_d          = PC_TURN;
            pc_fire_strobe_d = 1'b1;
          end
        end
      end
      PC_TURN: begin
        state_d = PC_WAIT;
      end
      PC_WAIT: begin
        if (bus.result_valid) begin
          pc_score_d = pc_score_inc;
          if (pc_score_inc == amount_q) begin
            state_d = LOSE;
          end else begin
            state_d      = P_TURN;
            turn_timer_d = TURN_RELOAD;
          end
        end
      end
      WIN, LOSE: begin
        if (press) begin
          state_d        = IDLE;
          amount_d       = 3'd0;
          ships_placed_d = 3'd0;
          player_score_d = 3'd0;
          pc_score_d     = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // confirm_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      confirm_q        <= 1'b1;
      amount_q         <= 3'd0;
      ships_placed_q   <= 3'd0;
      player_score_q   <= 3'd0;
      pc_score_q       <= 3'd0;
      turn_timer_q     <= 4'd0;
      ships_decided_q  <= 1'b0;
      place_strobe_q   <= 1'b0;
      fire_strobe_q    <= 1'b0;
      auto_fire_q      <= 1'b0;
      pc_fire_strobe_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      confirm_q        <= bus.confirm;
      amount_q         <= amount_d;
      ships_placed_q   <= ships_placed_d;
      player_score_q   <= player_score_d;
      pc_score_q       <= pc_score_d;
      turn_timer_q     <= turn_timer_d;
      ships_decided_q  <= ships_decided_d;
      place_strobe_q   <= place_strobe_d;
      fire_strobe_q    <= fire_strobe_d;
      auto_fire_q      <= auto_fire_d;
      pc_fire_strobe_q <= pc_fire_strobe_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.ships_decided  = ships_decided_q;
  assign bus.place_strobe   = place_strobe_q;
  assign bus.ships_placed   = ships_placed_q;
  assign bus.fire_strobe    = fire_strobe_q;
  assign bus.auto_fire      = auto_fire_q;
  assign bus.pc_fire_strobe = pc_fire_strobe_q;
  assign bus.turn_timer     = turn_timer_q;
  assign bus.player_score   = player_score_q;
  assign bus.pc_score       = pc_score_q;
endmodule

// File: tb/tb_battle_phase_ctrl.sv
// tb/tb_battle_phase_ctrl.sv - directed bench for battle_phase_ctrl with a cycle-level game model
module tb_battle_phase_ctrl;
  localparam int TS = 15;
  localparam int MS = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   cmp_en;

  battle_phase_ctrl_if bus_if ();

  battle_phase_ctrl #(.TURN_SECS(TS), .MAX_SHIPS(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Game model: phase numbers follow the published encoding, scores and counts as plain ints.
  int m_phase, m_amt, m_placed, m_timer, m_ps, m_cs;
  int m_dec, m_plc, m_fire, m_auto, m_pcf;
  bit m_btn_prev, m_pressed, m_expire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_amt = 0; m_placed = 0; m_timer = 0; m_ps = 0; m_cs = 0;
      m_dec = 0; m_plc = 0; m_fire = 0; m_auto = 0; m_pcf = 0;
      m_btn_prev = 1'b1;
    end else begin
      m_pressed  = bus_if.confirm && !m_btn_prev;
      m_btn_prev = bus_if.confirm;
      m_dec = 0; m_plc = 0; m_fire = 0; m_auto = 0; m_pcf = 0;
      if (m_phase == 0) begin
        if (m_pressed) begin m_phase = 1; m_amt = 0; m_placed = 0; m_ps = 0; m_cs = 0; end
      end else if (m_phase == 1) begin
        if (m_pressed && int'(bus_if.ship_amount) >= 1 && int'(bus_if.ship_amount) <= MS) begin
          m_amt = int'(bus_if.ship_amount); m_dec = 1; m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (m_placed == m_amt) begin m_phase = 3; m_timer = TS; end
        else if (m_pressed && bus_if.place_valid) begin m_placed++; m_plc = 1; end
      end else if (m_phase == 3) begin
        m_expire = bus_if.tick_1hz && m_timer == 1;
        if (bus_if.tick_1hz && m_timer > 0) m_timer--;
        if (m_pressed && bus_if.shot_valid) begin m_fire = 1; m_phase = 4; end
        else if (m_expire) begin m_fire = 1; m_auto = 1; m_phase = 4; end
      end else if (m_phase == 4) begin
        if (bus_if.result_valid) begin
          m_ps += int'(bus_if.result_sunk);
          if (m_ps == m_amt) m_phase = 7;
          else begin m_phase = 5; m_pcf = 1; end
        end
      end else if (m_phase == 5) begin
        m_phase = 6;
      end else if (m_phase == 6) begin
        if (bus_if.result_valid) begin
          m_cs += int'(bus_if.result_sunk);
          if (m_cs == m_amt) m_phase = 8;
          else begin m_phase = 3; m_timer = TS; end
        end
      end else if (m_phase == 7 || m_phase == 8) begin
        if (m_pressed) begin m_phase = 0; m_amt = 0; m_placed = 0; m_ps = 0; m_cs = 0; end
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("state", int'(bus_if.state), m_phase);
      chk("ships_decided", int'(bus_if.ships_decided), m_dec);
      chk("place_strobe", int'(bus_if.place_strobe), m_plc);
      chk("ships_placed", int'(bus_if.ships_placed), m_placed);
      chk("fire_strobe", int'(bus_if.fire_strobe), m_fire);
      chk("auto_fire", int'(bus_if.auto_fire), m_auto);
      chk("pc_fire_strobe", int'(bus_if.pc_fire_strobe), m_pcf);
      chk("turn_timer", int'(bus_if.turn_timer), m_timer);
      chk("player_score", int'(bus_if.player_score), m_ps);
      chk("pc_score", int'(bus_if.pc_score), m_cs);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    bus_if.confirm = 1'b1; cyc();
    bus_if.confirm = 1'b0; cyc();
  endtask

  task automatic tick_pulse();
    bus_if.tick_1hz = 1'b1; cyc();
    bus_if.tick_1hz = 1'b0; cyc();
  endtask

  task automatic result(input bit sunk);
    bus_if.result_valid = 1'b1; bus_if.result_sunk = sunk; cyc();
    bus_if.result_valid = 1'b0; bus_if.result_sunk = 1'b0;
  endtask

  task automatic new_game(input int amt);
    press();
    bus_if.ship_amount = 3'(amt); press();
    bus_if.place_valid = 1'b1;
    repeat (amt) press();
    bus_if.place_valid = 1'b0;
    cyc();
  endtask

  task automatic shoot();
    bus_if.shot_valid = 1'b1; press(); bus_if.shot_valid = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_state"}, int'(bus_if.state), 0);
    chk({tag, "_strobes"}, int'({bus_if.ships_decided, bus_if.place_strobe, bus_if.fire_strobe,
                                 bus_if.auto_fire, bus_if.pc_fire_strobe}), 0);
    chk({tag, "_counts"}, int'({bus_if.ships_placed, bus_if.turn_timer,
                                bus_if.player_score, bus_if.pc_score}), 0);
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b1;
    rst = 1'b1;
    bus_if.tick_1hz = 0; bus_if.confirm = 0; bus_if.ship_amount = 0; bus_if.place_valid = 0;
    bus_if.shot_valid = 0; bus_if.result_valid = 0; bus_if.result_sunk = 0;
    repeat (3) cyc();
    all_zero("in_reset");
    rst = 1'b0; cyc();
    chk("reset_state", int'(bus_if.state), 0);

    press();
    chk("idle_to_decide", int'(bus_if.state), 1);
    bus_if.ship_amount = 3'd0; press();
    chk("amount0_stays", int'(bus_if.state), 1);
    bus_if.ship_amount = 3'd3; bus_if.confirm = 1'b1; cyc();
    chk("decided_pulse", int'(bus_if.ships_decided), 1);
    chk("decide_to_place", int'(bus_if.state), 2);
    bus_if.confirm = 1'b0; cyc();
    chk("decided_one_cycle", int'(bus_if.ships_decided), 0);

    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    press(); bus_if.ship_amount = 3'd2; press();
    bus_if.place_valid = 1'b0; press();
    chk("place_invalid_ignored", int'(bus_if.ships_placed), 0);
    bus_if.place_valid = 1'b1; press(); press(); bus_if.place_valid = 1'b0;
    chk("placed_two", int'(bus_if.ships_placed), 2);
    chk("enter_p_turn", int'(bus_if.state), 3);
    chk("timer_loaded", int'(bus_if.turn_timer), 15);

    for (int i = 1; i <= 15; i++) begin
      bus_if.tick_1hz = 1'b1; cyc();
      chk("timer_countdown", int'(bus_if.turn_timer), 15 - i);
      if (i == 15) begin
        chk("timeout_fire", int'(bus_if.fire_strobe), 1);
        chk("timeout_auto", int'(bus_if.auto_fire), 1);
        chk("timeout_state", int'(bus_if.state), 4);
      end
      bus_if.tick_1hz = 1'b0; cyc();
    end
    tick_pulse();
    chk("timer_holds_p_wait", int'(bus_if.turn_timer), 0);

    result(1'b0);
    chk("pc_turn_entry", int'(bus_if.state), 5);
    chk("pc_fire_pulse", int'(bus_if.pc_fire_strobe), 1);
    cyc();
    chk("pc_wait", int'(bus_if.state), 6);
    result(1'b0);
    chk("back_to_p_turn", int'(bus_if.state), 3);
    chk("timer_reloaded", int'(bus_if.turn_timer), 15);

    result(1'b1);
    chk("stray_result_ignored", int'(bus_if.player_score), 0);
    press();
    chk("shot_invalid_ignored", int'(bus_if.state), 3);
    repeat (14) tick_pulse();
    chk("timer_at_one", int'(bus_if.turn_timer), 1);
    bus_if.confirm = 1'b1; bus_if.shot_valid = 1'b1; bus_if.tick_1hz = 1'b1; cyc();
    chk("manual_wins_fire", int'(bus_if.fire_strobe), 1);
    chk("manual_wins_auto", int'(bus_if.auto_fire), 0);
    chk("manual_wins_state", int'(bus_if.state), 4);
    bus_if.confirm = 1'b0; bus_if.shot_valid = 1'b0; bus_if.tick_1hz = 1'b0; cyc();

    result(1'b1);
    chk("player_hit", int'(bus_if.player_score), 1);
    cyc();
    result(1'b1);
    chk("pc_hit", int'(bus_if.pc_score), 1);
    chk("pc_hit_state", int'(bus_if.state), 3);
    shoot();
    result(1'b1);
    chk("win_state", int'(bus_if.state), 7);
    chk("win_score", int'(bus_if.player_score), 2);
    repeat (2) cyc();
    press();
    chk("win_to_idle", int'(bus_if.state), 0);
    chk("scores_cleared", int'(bus_if.player_score) + int'(bus_if.pc_score), 0);

    new_game(1);
    shoot();
    result(1'b1);
    chk("amt1_win_score", int'(bus_if.player_score), 1);
    chk("amt1_win_state", int'(bus_if.state), 7);
    press();
    chk("amt1_idle", int'(bus_if.state), 0);

    new_game(1);
    shoot();
    result(1'b0);
    cyc();
    result(1'b1);
    chk("lose_state", int'(bus_if.state), 8);
    chk("lose_pc_score", int'(bus_if.pc_score), 1);
    press();
    chk("lose_to_idle", int'(bus_if.state), 0);

    new_game(2);
    shoot();
    chk("pre_reset_p_wait", int'(bus_if.state), 4);
    bus_if.confirm = 1'b1; cyc();
    rst = 1'b1; #1;
    all_zero("async_reset");
    cyc(); rst = 1'b0;
    repeat (3) cyc();
    chk("held_confirm_no_press", int'(bus_if.state), 0);
    bus_if.confirm = 1'b0; cyc();
    press();
    chk("repress_after_release", int'(bus_if.state), 1);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/battle_phase_ctrl.md
BATTLE_PHASE_CTRL -- requirements
Module: battle_phase_ctrl

Interface
REQ-001 SHALL have parameter TURN_SECS, default 15, meaning turn timeout reload value in seconds (range 1..15).
REQ-002 SHALL have parameter MAX_SHIPS, default 5, meaning largest legal fleet size.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 tick_1hz  in  1  one-cycle pulse, once per second.
REQ-006 confirm  in  1  synchronized player button level, active-high.
REQ-007 ship_amount  in  3  fleet size chosen by player.
REQ-008 place_valid  in  1  board reports cursor placement legal.
REQ-009 shot_valid  in  1  board reports target cell not yet fired.
REQ-010 result_valid  in  1  one-cycle pulse, board shot result ready.
REQ-011 result_sunk  in  1  qualifies result_valid: shot sank a ship.
REQ-012 state  out  4  current phase encoding.
REQ-013 ships_decided  out  1  one-cycle pulse, fleet size accepted.
REQ-014 place_strobe  out  1  one-cycle pulse, commit ship at cursor.
REQ-015 ships_placed  out  3  ships committed so far.
REQ-016 fire_strobe  out  1  one-cycle pulse, player shot issued.
REQ-017 auto_fire  out  1  qualifies fire_strobe: board chooses random cell (timeout).
REQ-018 pc_fire_strobe  out  1  one-cycle pulse, PC shot issued.
REQ-019 turn_timer  out  4  seconds remaining in player turn.
REQ-020 player_score / pc_score  out  3 each  enemy ships sunk by each side.

Function
REQ-021 States/encoding: IDLE=0, DECIDE=1, PLACE=2, P_TURN=3, P_WAIT=4, PC_TURN=5, PC_WAIT=6, WIN=7, LOSE=8; all other codes return to IDLE next cycle.
REQ-022 confirm SHALL be edge-detected internally; an action occurs only on the first cycle confirm is high after being low ("press").
REQ-023 IDLE: press -> DECIDE; scores, ships_placed, latched amount cleared.
REQ-024 DECIDE: press with 1 <= ship_amount <= MAX_SHIPS -> latch amount, ships_decided high for exactly that cycle, state PLACE next cycle; otherwise stay, no pulse.
REQ-025 PLACE: press with place_valid=1 -> place_strobe for one cycle, ships_placed += 1; press with place_valid=0 ignored.
REQ-026 PLACE: when ships_placed reaches latched amount -> P_TURN the following cycle; ships_placed never exceeds latched amount.
REQ-027 P_TURN entry SHALL load turn_timer = TURN_SECS; each tick_1hz decrements it.
REQ-028 P_TURN: press with shot_valid=1 -> fire_strobe, auto_fire=0, state P_WAIT; press with shot_valid=0 ignored.
REQ-029 P_TURN: tick_1hz while turn_timer=1 -> turn_timer=0, fire_strobe with auto_fire=1, state P_WAIT.
REQ-030 Press with shot_valid=1 and expiring tick in same cycle -> manual shot wins (auto_fire=0).
REQ-031 P_WAIT: result_valid -> if result_sunk, player_score += 1; then WIN if player_score equals latched amount, else PC_TURN.
REQ-032 PC_TURN: pc_fire_strobe one cycle on entry, state PC_WAIT next cycle.
REQ-033 PC_WAIT: result_valid -> if result_sunk, pc_score += 1; then LOSE if pc_score equals latched amount, else P_TURN (timer reloaded).
REQ-034 result_valid outside P_WAIT/PC_WAIT, and tick_1hz outside P_TURN, SHALL be ignored; turn_timer holds outside P_TURN.
REQ-035 WIN/LOSE: hold, scores visible; press -> IDLE.
REQ-036 Strobe outputs SHALL be registered, never high two consecutive cycles.

Reset
REQ-037 rst high SHALL immediately force state=IDLE and all outputs to 0, in any state, mid-turn included.
REQ-038 After rst deasserts, a confirm already held high SHALL NOT count as a press until released.

Verification
REQ-039 Reset, press, ship_amount=0 press -> stays DECIDE, no ships_decided; ship_amount=3 press -> one ships_decided pulse, state=2.
REQ-040 amount=2, presses with place_valid=0,1,1 -> two place_strobe pulses, ships_placed=2, state=3 with turn_timer=15.
REQ-041 P_TURN, 15 ticks no press -> turn_timer 15..0, fire_strobe+auto_fire on 15th tick, state=4.
REQ-042 amount=1, press shot_valid=1, result_valid+result_sunk -> player_score=1, state=7; press -> IDLE, scores 0.
REQ-043 PC_WAIT with result_sunk reaching amount -> state=8; non-sunk result -> state=3, timer reloaded.
REQ-044 rst pulsed in P_WAIT with confirm held -> all outputs 0, IDLE; no press until confirm released and re-pressed.
